// File: rtl/kernel_ctrl_pkg.sv
// Shared register offsets, CTRL bit positions, FSM encodings and AXI response codes
// for the multi-argument kernel control slave.
package kernel_ctrl_pkg;

  localparam logic [31:0] ADDR_CTRL = 32'h000;
  localparam logic [31:0] ADDR_GIE  = 32'h004;
  localparam logic [31:0] ADDR_IER  = 32'h008;
  localparam logic [31:0] ADDR_ISR  = 32'h00C;
  localparam logic [31:0] ARG_BASE  = 32'h010;

  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_IDLE  = 2;
  localparam int CTRL_READY = 3;
  localparam int CTRL_AUTO  = 7;

  localparam logic [1:0] WRIDLE  = 2'd0;
  localparam logic [1:0] WRDATA  = 2'd1;
  localparam logic [1:0] WRRESP  = 2'd2;
  localparam logic [1:0] WRRESET = 2'd3;

  localparam logic [1:0] RDIDLE  = 2'd0;
  localparam logic [1:0] RDDATA  = 2'd1;
  localparam logic [1:0] RDRESET = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word w < num_scalars is scalar w (8-byte stride, upper slot reserved);
  // the rest are pointer halves packed at a 4-byte stride after the scalar block.
  function automatic logic [31:0] arg_word_addr(input int num_scalars, input int w);
    if (w < num_scalars) return ARG_BASE + 32'(8 * w);
    return ARG_BASE + 32'(4 * num_scalars + 4 * w);
  endfunction

endpackage

// File: rtl/kernel_ctrl_arg_regs.sv
// Bank of byte-maskable 32-bit argument words with an indexed write port and a
// combinational indexed read mux; all words are also exposed flat.
module kernel_ctrl_arg_regs #(
  parameter int NUM_WORDS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      we_i,
  input  logic [IDX_W-1:0]          widx_i,
  input  logic [31:0]               wdata_i,
  input  logic [3:0]                wstrb_i,
  input  logic [IDX_W-1:0]          ridx_i,
  output logic [31:0]               rdata_o,
  output logic [32*NUM_WORDS-1:0]   words_o
);

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
    logic [31:0] word_q, word_d;

    always_comb begin
      word_d = word_q;
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) word_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) word_q <= '0;
      else if (we_i && (widx_i == IDX_W'(g))) word_q <= word_d;
    end

    assign words_o[32*g +: 32] = word_q;
  end

  always_comb begin
    rdata_o = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (ridx_i == IDX_W'(w)) rdata_o = words_o[32*w +: 32];
    end
  end

endmodule

// File: rtl/kernel_ctrl_s_axi_multi.sv
// AXI4-Lite control slave for SDx kernels: N scalars, M 64-bit pointers, ap_ready,
// auto-restart and done/ready interrupts. Define KERNEL_CTRL_S_AXI_SLVERR_EN for SLVERR on unmapped access.
module kernel_ctrl_s_axi_multi
  import kernel_ctrl_pkg::*;
#(
  parameter int C_ADDR_WIDTH  = 12,
  parameter int C_DATA_WIDTH  = 32,
  parameter int C_NUM_SCALARS = 4,
  parameter int C_NUM_PTRS    = 2
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       aclk_en,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [C_ADDR_WIDTH-1:0]    awaddr,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [31:0]                wdata,
  input  logic [3:0]                 wstrb,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [1:0]                 bresp,
  input  logic                       arvalid,
  output logic                       arready,
  input  logic [C_ADDR_WIDTH-1:0]    araddr,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [31:0]                rdata,
  output logic [1:0]                 rresp,
  output logic                       interrupt,
  output logic                       ap_start,
  input  logic                       ap_idle,
  input  logic                       ap_done,
  input  logic                       ap_ready,
  output logic [32*C_NUM_SCALARS-1:0] scalars,
  output logic [64*C_NUM_PTRS-1:0]    ptrs
);

  localparam int NUM_WORDS = C_NUM_SCALARS + 2 * C_NUM_PTRS;
  localparam int IDX_W     = $clog2(NUM_WORDS);

  if (C_DATA_WIDTH != 32 || C_NUM_SCALARS < 1 || C_NUM_SCALARS > 16 ||
      C_NUM_PTRS < 1 || C_NUM_PTRS > 16) begin : g_bad_param
    $error("kernel_ctrl_s_axi_multi: unsupported parameter value");
  end

  logic [1:0]              wstate_q, wstate_d, rstate_q, rstate_d;
  logic [C_ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]             rdata_q, rdata_d, arg_rdata;
  logic                    w_hs, ar_hs;

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      WRIDLE:  if (awvalid) wstate_d = WRDATA;
      WRDATA:  if (wvalid)  wstate_d = WRRESP;
      WRRESP:  if (bready)  wstate_d = WRIDLE;
      default: wstate_d = WRIDLE;
    endcase
    rstate_d = rstate_q;
    case (rstate_q)
      RDIDLE:  if (arvalid) rstate_d = RDDATA;
      RDDATA:  if (rready)  rstate_d = RDIDLE;
      default: rstate_d = RDIDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q <= WRRESET;
      rstate_q <= RDRESET;
    end else if (aclk_en) begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
    end
  end

  assign awready = (wstate_q == WRIDLE);
  assign wready  = (wstate_q == WRDATA);
  assign bvalid  = (wstate_q == WRRESP);
  assign arready = (rstate_q == RDIDLE);
  assign rvalid  = (rstate_q == RDDATA);
  assign w_hs    = aclk_en && wready && wvalid;
  assign ar_hs   = aclk_en && arready && arvalid;

  always_ff @(posedge aclk) begin
    if (aclk_en && awvalid && awready) waddr_q <= awaddr;
  end

  // Full-address decode of control registers and argument words
  logic wr_ctrl, wr_gie, wr_ier, wr_isr, rd_ctrl, rd_gie, rd_ier, rd_isr;
  logic wr_arg_hit, rd_arg_hit;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign wr_ctrl = (waddr_q == C_ADDR_WIDTH'(ADDR_CTRL));
  assign wr_gie  = (waddr_q == C_ADDR_WIDTH'(ADDR_GIE));
  assign wr_ier  = (waddr_q == C_ADDR_WIDTH'(ADDR_IER));
  assign wr_isr  = (waddr_q == C_ADDR_WIDTH'(ADDR_ISR));
  assign rd_ctrl = (araddr == C_ADDR_WIDTH'(ADDR_CTRL));
  assign rd_gie  = (araddr == C_ADDR_WIDTH'(ADDR_GIE));
  assign rd_ier  = (araddr == C_ADDR_WIDTH'(ADDR_IER));
  assign rd_isr  = (araddr == C_ADDR_WIDTH'(ADDR_ISR));

  always_comb begin
    wr_arg_hit = 1'b0;
    wr_idx     = '0;
    rd_arg_hit = 1'b0;
    rd_idx     = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (waddr_q == C_ADDR_WIDTH'(arg_word_addr(C_NUM_SCALARS, w))) begin
        wr_arg_hit = 1'b1;
        wr_idx     = IDX_W'(w);
      end
      if (araddr == C_ADDR_WIDTH'(arg_word_addr(C_NUM_SCALARS, w))) begin
        rd_arg_hit = 1'b1;
        rd_idx     = IDX_W'(w);
      end
    end
  end

  logic start_q, start_d, done_q, done_d, ready_q, ready_d, auto_q, auto_d, gie_q, gie_d;
  logic [1:0] ier_q, ier_d, isr_q, isr_d;
  logic ctrl_we, ctrl_rd, byte0_we;

  assign byte0_we = w_hs && wstrb[0];
  assign ctrl_we  = byte0_we && wr_ctrl;
  assign ctrl_rd  = ar_hs && rd_ctrl;

  always_comb begin
    start_d = start_q;
    auto_d  = auto_q;
    gie_d   = gie_q;
    ier_d   = ier_q;
    if (ap_ready && !auto_q)           start_d = 1'b0;
    if (ap_done && auto_q)             start_d = 1'b1;
    if (ctrl_we && wdata[CTRL_START])  start_d = 1'b1;
    if (ctrl_we)                       auto_d  = wdata[CTRL_AUTO];
    if (byte0_we && wr_gie)            gie_d   = wdata[0];
    if (byte0_we && wr_ier)            ier_d   = wdata[1:0];
    // A status event in the same cycle as the clearing read wins
    done_d  = ap_done  | (done_q  & ~ctrl_rd);
    ready_d = ap_ready | (ready_q & ~ctrl_rd);
    isr_d   = isr_q;
    if (byte0_we && wr_isr) isr_d = isr_q ^ wdata[1:0];
    isr_d = isr_d | (ier_q & {ap_ready, ap_done});
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      auto_q  <= 1'b0;
      gie_q   <= 1'b0;
      ier_q   <= '0;
      isr_q   <= '0;
    end else if (aclk_en) begin
      start_q <= start_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      auto_q  <= auto_d;
      gie_q   <= gie_d;
      ier_q   <= ier_d;
      isr_q   <= isr_d;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_ctrl) begin
      rdata_d[CTRL_START] = start_q;
      rdata_d[CTRL_DONE]  = done_q;
      rdata_d[CTRL_IDLE]  = ap_idle;
      rdata_d[CTRL_READY] = ready_q;
      rdata_d[CTRL_AUTO]  = auto_q;
    end else if (rd_gie) begin
      rdata_d[0] = gie_q;
    end else if (rd_ier) begin
      rdata_d[1:0] = ier_q;
    end else if (rd_isr) begin
      rdata_d[1:0] = isr_q;
    end else if (rd_arg_hit) begin
      rdata_d = arg_rdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (ar_hs) rdata_q <= rdata_d;
  end

  logic [32*NUM_WORDS-1:0] words;
  logic                    arg_we;
  assign arg_we = w_hs && wr_arg_hit;

  kernel_ctrl_arg_regs #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_arg_regs (
    .clk_i   (aclk),
    .rst_i   (areset),
    .we_i    (arg_we),
    .widx_i  (wr_idx),
    .wdata_i (wdata),
    .wstrb_i (wstrb),
    .ridx_i  (rd_idx),
    .rdata_o (arg_rdata),
    .words_o (words)
  );

`ifdef KERNEL_CTRL_S_AXI_SLVERR_EN
  logic       wr_hit, rd_hit;
  logic [1:0] bresp_q, rresp_q;
  assign wr_hit = wr_ctrl | wr_gie | wr_ier | wr_isr | wr_arg_hit;
  assign rd_hit = rd_ctrl | rd_gie | rd_ier | rd_isr | rd_arg_hit;

  always_ff @(posedge aclk) begin
    if (areset) begin
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
    end else begin
      if (w_hs)  bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      if (ar_hs) rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end
  assign bresp = bresp_q;
  assign rresp = rresp_q;
`else
  assign bresp = RESP_OKAY;
  assign rresp = RESP_OKAY;
`endif

  assign rdata     = rdata_q;
  assign ap_start  = start_q;
  assign interrupt = gie_q & (|isr_q);
  assign scalars   = words[32*C_NUM_SCALARS-1:0];
  assign ptrs      = words[32*NUM_WORDS-1:32*C_NUM_SCALARS];

endmodule

// File: tb/tb_kernel_ctrl_s_axi_multi.sv
// Self-checking bench for kernel_ctrl_s_axi_multi: register map, strobes, ap_* handshake,
// auto-restart, interrupts, unmapped access, clock enable and reset behaviour.
module tb_kernel_ctrl_s_axi_multi;

  logic         aclk = 1'b0;
  logic         areset, aclk_en;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic [11:0]  awaddr, araddr;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         arvalid, arready, rvalid, rready;
  logic         interrupt, ap_start, ap_idle, ap_done, ap_ready;
  logic [127:0] scalars, ptrs;

  int total = 0;
  int bad   = 0;

  logic [33:0] exp_q[$];
  logic [33:0] e;
  logic [31:0] rd;
  logic [1:0]  rr, br;

`ifdef KERNEL_CTRL_S_AXI_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  kernel_ctrl_s_axi_multi #(
    .C_ADDR_WIDTH(12), .C_DATA_WIDTH(32), .C_NUM_SCALARS(4), .C_NUM_PTRS(2)
  ) dut (
    .aclk(aclk), .areset(areset), .aclk_en(aclk_en),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .interrupt(interrupt), .ap_start(ap_start), .ap_idle(ap_idle),
    .ap_done(ap_done), .ap_ready(ap_ready),
    .scalars(scalars), .ptrs(ptrs)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit rdy_pulse, output logic [1:0] resp);
    int n;
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    if (!awready) begin total++; bad++; $display("FAIL aw_timeout addr=%h", a); end
    tick();
    awvalid = 1'b0;
    n = 0;
    while (!wready && n < 50) begin tick(); n++; end
    if (!wready) begin total++; bad++; $display("FAIL w_timeout addr=%h", a); end
    if (rdy_pulse) ap_ready = 1'b1;
    tick();
    wvalid = 1'b0;
    ap_ready = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (!bvalid) begin total++; bad++; $display("FAIL b_timeout addr=%h", a); end
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    arvalid = 1'b1; araddr = a;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) begin total++; bad++; $display("FAIL ar_timeout addr=%h", a); end
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    if (!rvalid) begin total++; bad++; $display("FAIL r_timeout addr=%h", a); end
    d = rdata;
    resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  task automatic pulse_done();
    ap_done = 1'b1; tick(); ap_done = 1'b0;
  endtask

  task automatic pulse_ready();
    ap_ready = 1'b1; tick(); ap_ready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) tick();
    total++; if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin bad++;
      $display("FAIL rst_handshake got=%b exp=00000", {awready, wready, bvalid, arready, rvalid}); end
    total++; if ({ap_start, interrupt, bresp, rresp} !== 6'b0) begin bad++;
      $display("FAIL rst_ctrl got=%b exp=000000", {ap_start, interrupt, bresp, rresp}); end
    total++; if ({scalars, ptrs} !== 256'b0) begin bad++;
      $display("FAIL rst_args got=%h exp=0", {scalars, ptrs}); end
    areset = 1'b0;
    total++; if ({awready, arready} !== 2'b00) begin bad++;
      $display("FAIL rst_after_cycle got=%b exp=00", {awready, arready}); end
    tick();
    total++; if ({awready, arready} !== 2'b11) begin bad++;
      $display("FAIL rst_idle got=%b exp=11", {awready, arready}); end
  endtask

  task automatic test_wstrb();
    axi_write(12'h010, 32'hDEADBEEF, 4'b0101, 1'b0, br);
    exp_q.push_back({2'b00, 32'h00AD00EF});
    axi_write(12'h028, 32'hCAFEF00D, 4'b1111, 1'b0, br);
    exp_q.push_back({2'b00, 32'hCAFEF00D});
    axi_read(12'h010, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL wstrb_read got=%h exp=%h", {rr, rd}, e); end
    axi_read(12'h028, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL scalar3_read got=%h exp=%h", {rr, rd}, e); end
    total++; if (scalars !== {32'hCAFEF00D, 64'h0, 32'h00AD00EF}) begin bad++;
      $display("FAIL scalars_port got=%h exp=%h", scalars, {32'hCAFEF00D, 64'h0, 32'h00AD00EF}); end
  endtask

  task automatic test_ptrs();
    axi_write(12'h038, 32'h11223344, 4'hF, 1'b0, br);
    axi_write(12'h03C, 32'h55667788, 4'hF, 1'b0, br);
    total++; if (ptrs[127:64] !== 64'h5566778811223344) begin bad++;
      $display("FAIL ptr1_port got=%h exp=5566778811223344", ptrs[127:64]); end
    total++; if (ptrs[63:0] !== 64'h0) begin bad++; $display("FAIL ptr0_port got=%h exp=0", ptrs[63:0]); end
    exp_q.push_back({2'b00, 32'h55667788});
    axi_read(12'h03C, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL ptr1_hi_read got=%h exp=%h", {rr, rd}, e); end
  endtask

  task automatic test_ctrl();
    axi_write(12'h000, 32'h1, 4'h1, 1'b0, br);
    total++; if (ap_start !== 1'b1) begin bad++; $display("FAIL start_set got=%b exp=1", ap_start); end
    ap_ready = 1'b1;
    total++; if (ap_start !== 1'b1) begin bad++; $display("FAIL start_before_ready got=%b exp=1", ap_start); end
    tick(); ap_ready = 1'b0;
    total++; if (ap_start !== 1'b0) begin bad++; $display("FAIL start_clear got=%b exp=0", ap_start); end
    pulse_done();
    exp_q.push_back({2'b00, 32'h0000000A});
    exp_q.push_back({2'b00, 32'h00000000});
    axi_read(12'h000, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL ctrl_status got=%h exp=%h", {rr, rd}, e); end
    axi_read(12'h000, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL ctrl_cor got=%h exp=%h", {rr, rd}, e); end
    ap_idle = 1'b1;
    exp_q.push_back({2'b00, 32'h00000004});
    axi_read(12'h000, rd, rr); e = exp_q.pop_front();
    ap_idle = 1'b0;
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL ctrl_idle got=%h exp=%h", {rr, rd}, e); end
  endtask

  task automatic test_auto_restart();
    axi_write(12'h000, 32'h81, 4'h1, 1'b0, br);
    pulse_ready();
    total++; if (ap_start !== 1'b1) begin bad++; $display("FAIL auto_keep_ready got=%b exp=1", ap_start); end
    pulse_done();
    total++; if (ap_start !== 1'b1) begin bad++; $display("FAIL auto_keep_done got=%b exp=1", ap_start); end
    exp_q.push_back({2'b00, 32'h0000008B});
    axi_read(12'h000, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL auto_ctrl got=%h exp=%h", {rr, rd}, e); end
    axi_write(12'h000, 32'h0, 4'h1, 1'b0, br);
    total++; if (ap_start !== 1'b1) begin bad++; $display("FAIL write0_noeffect got=%b exp=1", ap_start); end
    pulse_ready();
    total++; if (ap_start !== 1'b0) begin bad++; $display("FAIL auto_off_clear got=%b exp=0", ap_start); end
  endtask

  task automatic test_irq();
    axi_write(12'h004, 32'h1, 4'h1, 1'b0, br);
    axi_write(12'h008, 32'h3, 4'h1, 1'b0, br);
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", interrupt); end
    pulse_done();
    total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL irq_done got=%b exp=1", interrupt); end
    exp_q.push_back({2'b00, 32'h1});
    axi_read(12'h00C, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL isr_read got=%h exp=%h", {rr, rd}, e); end
    axi_write(12'h00C, 32'h1, 4'h1, 1'b0, br);
    total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL irq_toggle got=%b exp=0", interrupt); end
    pulse_ready();
    axi_write(12'h00C, 32'h2, 4'h1, 1'b1, br);
    exp_q.push_back({2'b00, 32'h2});
    axi_read(12'h00C, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL isr_set_prio got=%h exp=%h", {rr, rd}, e); end
    total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL irq_ready got=%b exp=1", interrupt); end
    exp_q.push_back({2'b00, 32'h3});
    axi_read(12'h008, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL ier_read got=%h exp=%h", {rr, rd}, e); end
  endtask

  task automatic test_unmapped();
    axi_write(12'h0FC, 32'hFFFFFFFF, 4'hF, 1'b0, br);
    total++; if (br !== UNMAP_RESP) begin bad++; $display("FAIL unmap_bresp got=%b exp=%b", br, UNMAP_RESP); end
    axi_write(12'h014, 32'hFFFFFFFF, 4'hF, 1'b0, br);
    total++; if (br !== UNMAP_RESP) begin bad++; $display("FAIL rsvd_bresp got=%b exp=%b", br, UNMAP_RESP); end
    total++; if (scalars !== {32'hCAFEF00D, 64'h0, 32'h00AD00EF}) begin bad++;
      $display("FAIL unmap_noeffect got=%h exp=%h", scalars, {32'hCAFEF00D, 64'h0, 32'h00AD00EF}); end
    exp_q.push_back({UNMAP_RESP, 32'h0});
    exp_q.push_back({UNMAP_RESP, 32'h0});
    axi_read(12'h0FC, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL unmap_read got=%h exp=%h", {rr, rd}, e); end
    axi_read(12'h014, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL rsvd_read got=%h exp=%h", {rr, rd}, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] mdl[8];
    logic [11:0] a;
    for (int i = 0; i < 8; i++) begin
      a = (i < 4) ? 12'h010 + 12'(8 * i) : 12'h030 + 12'(4 * (i - 4));
      mdl[i] = $urandom;
      axi_write(a, mdl[i], 4'hF, 1'b0, br);
      exp_q.push_back({2'b00, mdl[i]});
    end
    for (int i = 0; i < 8; i++) begin
      a = (i < 4) ? 12'h010 + 12'(8 * i) : 12'h030 + 12'(4 * (i - 4));
      axi_read(a, rd, rr); e = exp_q.pop_front();
      total++; if ({rr, rd} !== e) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i, {rr, rd}, e); end
    end
    total++; if ({ptrs, scalars} !== {mdl[7], mdl[6], mdl[5], mdl[4], mdl[3], mdl[2], mdl[1], mdl[0]}) begin
      bad++; $display("FAIL b2b_ports got=%h exp=%h", {ptrs, scalars},
                      {mdl[7], mdl[6], mdl[5], mdl[4], mdl[3], mdl[2], mdl[1], mdl[0]}); end
  endtask

  task automatic test_clk_en();
    exp_q.push_back({2'b00, 32'h0000000A});
    axi_read(12'h000, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL clken_pre got=%h exp=%h", {rr, rd}, e); end
    aclk_en = 1'b0;
    arvalid = 1'b1; araddr = 12'h000;
    ap_done = 1'b1;
    repeat (3) tick();
    ap_done = 1'b0;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL clken_hold got=%b exp=0", rvalid); end
    arvalid = 1'b0;
    aclk_en = 1'b1;
    exp_q.push_back({2'b00, 32'h00000000});
    axi_read(12'h000, rd, rr); e = exp_q.pop_front();
    total++; if ({rr, rd} !== e) begin bad++; $display("FAIL clken_gate got=%h exp=%h", {rr, rd}, e); end
  endtask

  task automatic test_reset_midway();
    int seen;
    awvalid = 1'b1; awaddr = 12'h010;
    arvalid = 1'b1; araddr = 12'h010;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    areset = 1'b1;
    tick(); tick();
    areset = 1'b0;
    seen = 0;
    bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (bvalid || rvalid) seen++;
      tick();
    end
    bready = 1'b0; rready = 1'b0;
    total++; if (seen !== 0) begin bad++; $display("FAIL abandon_resp got=%0d exp=0", seen); end
    total++; if ({awready, arready, scalars[31:0]} !== {2'b11, 32'h0}) begin bad++;
      $display("FAIL abandon_state got=%h exp=%h", {awready, arready, scalars[31:0]}, {2'b11, 32'h0}); end
  endtask

  initial begin
    areset = 1'b1; aclk_en = 1'b1;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    ap_idle = 1'b0; ap_done = 1'b0; ap_ready = 1'b0;
    test_reset();
    test_wstrb();
    test_ptrs();
    test_ctrl();
    test_auto_restart();
    test_irq();
    test_unmapped();
    test_back_to_back();
    test_clk_en();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
